mac16_mul32_seq: RTL and testbench



---
 rtl/mac16_mul32_seq_if.sv | 27 ++
 rtl/mac16_mul32_seq.sv | 149 ++++++++++++++
 tb/tb_mac16_mul32_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac16_mul32_seq_if.sv
// Request/response handshake plus the DSP operand/product bus of the RV32M multiply sequencer.
// slave = the sequencer; master = execute stage together with the DSP primitive.
interface mac16_mul32_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic        mac_ce;
  logic [31:0] mac_o;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready, mac_o,
    input  req_ready, resp_valid, resp_data, busy, mac_a, mac_b, mac_ce
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready, mac_o,
    output req_ready, resp_valid, resp_data, busy, mac_a, mac_b, mac_ce
  );
endinterface

// File: rtl/mac16_mul32_seq.sv
// RV32M MUL/MULH/MULHSU/MULHU on one unsigned 16x16 DSP: 4 issue steps, signed fix, 5-cycle latency (6 with MAC16_SEQ_OUTREG_EN).
// req_ready only in IDLE; the result is held in DONE until resp_ready, with no timeout.
module mac16_mul32_seq (
  input  logic             CLK,
  input  logic             RST_N,
  mac16_mul32_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_FIX   = 3'd2,
    S_DONE  = 3'd3
`ifdef MAC16_SEQ_OUTREG_EN
    , S_DRAIN = 3'd4
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d, step_nx, acc_idx;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] resp_data_q, resp_data_d, fix_hi;
  logic [63:0] acc_q, acc_d;
  logic [15:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic        mac_ce_q, mac_ce_d, acc_en;
  logic [5:0]  acc_sh;

  // Unsigned partial products over-count by b<<32 (a negative) and a<<32 (b negative).
  always_comb begin
    fix_hi = acc_q[63:32];
    if ((op_q == 2'd1 || op_q == 2'd2) && a_q[31]) fix_hi = fix_hi - b_q;
    if (op_q == 2'd1 && b_q[31])                   fix_hi = fix_hi - a_q;
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    resp_data_d = resp_data_q;
    mac_a_d     = 16'd0;
    mac_b_d     = 16'd0;
    mac_ce_d    = 1'b0;
    acc_en      = 1'b0;
    acc_idx     = step_q;
    acc_sh      = 6'd0;
    step_nx     = step_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          a_d      = bus.req_a;
          b_d      = bus.req_b;
          op_d     = bus.req_op;
          acc_d    = 64'd0;
          step_d   = 2'd0;
          mac_a_d  = bus.req_a[15:0];
          mac_b_d  = bus.req_b[15:0];
          mac_ce_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef MAC16_SEQ_OUTREG_EN
        // Product of step k appears one edge late, so accumulate step k-1 here.
        acc_en  = (step_q != 2'd0);
        acc_idx = step_q - 2'd1;
`else
        acc_en  = 1'b1;
        acc_idx = step_q;
`endif
        if (step_q != 2'd3) begin
          step_d   = step_nx;
          mac_a_d  = step_nx[0] ? a_q[31:16] : a_q[15:0];
          mac_b_d  = step_nx[1] ? b_q[31:16] : b_q[15:0];
          mac_ce_d = 1'b1;
        end else begin
`ifdef MAC16_SEQ_OUTREG_EN
          mac_ce_d = 1'b1;
          state_d  = S_DRAIN;
`else
          state_d  = S_FIX;
`endif
        end
      end
`ifdef MAC16_SEQ_OUTREG_EN
      S_DRAIN: begin
        acc_en  = 1'b1;
        acc_idx = 2'd3;
        state_d = S_FIX;
      end
`endif
      S_FIX: begin
        acc_d       = {fix_hi, acc_q[31:0]};
        resp_data_d = (op_q == 2'd0) ? acc_q[31:0] : fix_hi;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case (acc_idx)
      2'd0:    acc_sh = 6'd0;
      2'd3:    acc_sh = 6'd32;
      default: acc_sh = 6'd16;
    endcase
    if (acc_en) acc_d = acc_q + ({32'd0, bus.mac_o} << acc_sh);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      step_q      <= 2'd0;
      op_q        <= 2'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      acc_q       <= 64'd0;
      resp_data_q <= 32'd0;
      mac_a_q     <= 16'd0;
      mac_b_q     <= 16'd0;
      mac_ce_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      resp_data_q <= resp_data_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_ce_q    <= mac_ce_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.resp_data  = resp_data_q;
  assign bus.mac_a      = mac_a_q;
  assign bus.mac_b      = mac_b_q;
  assign bus.mac_ce     = mac_ce_q;

endmodule

// File: tb/tb_mac16_mul32_seq.sv
// Bench for mac16_mul32_seq: vector table, backpressure and mid-op reset sequences, random sweep vs a 64-bit model.
// Models the DSP as combinational, or registered on mac_ce when MAC16_SEQ_OUTREG_EN is defined.
module tb_mac16_mul32_seq;
  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  int   total = 0;
  int   bad   = 0;

`ifdef MAC16_SEQ_OUTREG_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  mac16_mul32_seq_if bus_if ();
  mac16_mul32_seq dut (.CLK(CLK), .RST_N(RST_N), .bus(bus_if));

  always #5 CLK = ~CLK;

`ifdef MAC16_SEQ_OUTREG_EN
  logic [31:0] dsp_q;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N)             dsp_q <= 32'd0;
    else if (bus_if.mac_ce) dsp_q <= 32'(bus_if.mac_a) * 32'(bus_if.mac_b);
  end
  assign bus_if.mac_o = dsp_q;
`else
  assign bus_if.mac_o = 32'(bus_if.mac_a) * 32'(bus_if.mac_b);
`endif

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    x = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    y = (op == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p = x * y;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int cyc;
    @(negedge CLK);
    bus_if.req_valid  = 1'b1;
    bus_if.req_op     = op;
    bus_if.req_a      = a;
    bus_if.req_b      = b;
    bus_if.resp_ready = 1'b1;
    cyc = 0;
    while (!bus_if.req_ready && cyc < 20) begin
      @(negedge CLK);
      cyc++;
    end
    if (!bus_if.req_ready) check("accept_timeout", {31'd0, bus_if.req_ready}, 32'd1);
    @(posedge CLK);
    #1;
    bus_if.req_valid = 1'b0;
    lat = 0;
    while (!bus_if.resp_valid && lat < 50) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    if (!bus_if.resp_valid) check("resp_timeout", {31'd0, bus_if.resp_valid}, 32'd1);
    res = bus_if.resp_data;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, held;
    int          lat, cyc;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[2] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[3] = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[4] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5] = '{2'd0, 32'h0001_2345, 32'h0001_0000, 32'h2345_0000};
    vecs[6] = '{2'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[7] = '{2'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFE};
    vecs[8] = '{2'd3, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000};
    vecs[9] = '{2'd0, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F};

    bus_if.req_valid  = 1'b0;
    bus_if.req_op     = 2'd0;
    bus_if.req_a      = 32'd0;
    bus_if.req_b      = 32'd0;
    bus_if.resp_ready = 1'b1;

    #12;
    check("rst_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
    check("rst_busy",       {31'd0, bus_if.busy},       32'd0);
    check("rst_mac_ce",     {31'd0, bus_if.mac_ce},     32'd0);
    check("rst_resp_data",  bus_if.resp_data,           32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    check("rst_mac_a",     {16'd0, bus_if.mac_a},     32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_data", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, LAT);
    end

    // Backpressure: result held in DONE; a pending request waits for the handshake.
    @(negedge CLK);
    bus_if.req_valid  = 1'b1;
    bus_if.req_op     = 2'd3;
    bus_if.req_a      = 32'hFFFF_FFFF;
    bus_if.req_b      = 32'hFFFF_FFFF;
    bus_if.resp_ready = 1'b0;
    @(posedge CLK);
    #1;
    bus_if.req_op = 2'd0;
    bus_if.req_a  = 32'h0001_2345;
    bus_if.req_b  = 32'h0001_0000;
    cyc = 0;
    while (!bus_if.resp_valid && cyc < 50) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    check("bp_latency", cyc, LAT);
    held = bus_if.resp_data;
    check("bp_data", held, 32'hFFFF_FFFE);
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK);
      #1;
      check($sformatf("bp_hold%0d_data", k), bus_if.resp_data, 32'hFFFF_FFFE);
      check($sformatf("bp_hold%0d_valid", k), {31'd0, bus_if.resp_valid}, 32'd1);
      check($sformatf("bp_hold%0d_req_ready", k), {31'd0, bus_if.req_ready}, 32'd0);
      check($sformatf("bp_hold%0d_busy", k), {31'd0, bus_if.busy}, 32'd1);
    end
    @(negedge CLK);
    bus_if.resp_ready = 1'b1;
    @(posedge CLK);
    #1;
    check("bp_after_hs_busy",  {31'd0, bus_if.busy},       32'd0);
    check("bp_after_hs_valid", {31'd0, bus_if.resp_valid}, 32'd0);
    @(posedge CLK);
    #1;
    check("bp_second_accepted", {31'd0, bus_if.busy}, 32'd1);
    bus_if.req_valid = 1'b0;
    cyc = 0;
    while (!bus_if.resp_valid && cyc < 50) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    check("bp_second_data", bus_if.resp_data, 32'h2345_0000);
    @(posedge CLK);
    #1;

    // Reset while step 2 operands are on the DSP bus.
    @(negedge CLK);
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = 2'd3;
    bus_if.req_a     = 32'h1234_5678;
    bus_if.req_b     = 32'h9ABC_DEF0;
    @(posedge CLK);
    #1;
    bus_if.req_valid = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("mid_step2_mac_a",  {16'd0, bus_if.mac_a},  32'h0000_5678);
    check("mid_step2_mac_b",  {16'd0, bus_if.mac_b},  32'h0000_9ABC);
    check("mid_step2_mac_ce", {31'd0, bus_if.mac_ce}, 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    check("mid_rst_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
    check("mid_rst_resp_data",  bus_if.resp_data,           32'd0);
    check("mid_rst_mac_a",      {16'd0, bus_if.mac_a},      32'd0);
    check("mid_rst_mac_b",      {16'd0, bus_if.mac_b},      32'd0);
    check("mid_rst_mac_ce",     {31'd0, bus_if.mac_ce},     32'd0);
    check("mid_rst_busy",       {31'd0, bus_if.busy},       32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      @(posedge CLK);
      #1;
      if (bus_if.resp_valid) check("mid_rst_no_response", {31'd0, bus_if.resp_valid}, 32'd0);
    end
    check("post_rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    run_op(2'd3, 32'd3, 32'd5, res, lat);
    check("post_rst_mulhu", res, 32'h0000_0000);
    run_op(2'd0, 32'd3, 32'd5, res, lat);
    check("post_rst_mul", res, 32'h0000_000F);
    check("post_rst_latency", lat, LAT);

    for (int i = 0; i < 4000; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0:       ra = 32'h8000_0000;
        1:       rb = 32'hFFFF_FFFF;
        2:       ra = 32'd0;
        3:       rb = 32'h8000_0000;
        default: ;
      endcase
      run_op(rop, ra, rb, res, lat);
      check($sformatf("rand%0d op%0d a=%h b=%h", i, rop, ra, rb), res, ref_mul(rop, ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
